cordic_cos_iter: RTL and testbench

- Iterative rotation-mode CORDIC engine that computes cos(theta) for a fixed-point angle in [-1, 1] rad.
- Sits directly upstream of the fixed-to-float packer and drives its result input.
- Output format: {sign, integer bit, WIDTH fraction bits}.
  - integer bit = 1 only for exactly 1.0.
  - otherwise the magnitude lies in [0.5, 1).
- Performs one micro-rotation per clock, with a valid/ready handshake on both sides.

---
 rtl/cordic_cos_iter.sv | 127 ++++++++++++
 tb/tb_cordic_cos_iter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cordic_cos_iter.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, returns cos(theta)
// as {sign, int, frac} with valid/ready handshakes on both sides.
module cordic_cos_iter #(
    parameter int unsigned WIDTH = 23,
    parameter int unsigned ITER  = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH+1:0] theta_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH+1:0] result_o
);

    localparam int unsigned DW = WIDTH + 4;
    localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef logic signed [DW-1:0] word_t;

    function automatic logic [ITER-1:0][DW-1:0] gen_atan();
        logic [ITER-1:0][DW-1:0] tab;
        for (int i = 0; i < ITER; i++) begin
            tab[i] = DW'(longint'($atan(1.0 / (2.0 ** i)) * (2.0 ** WIDTH)));
        end
        return tab;
    endfunction

    localparam logic [ITER-1:0][DW-1:0] AtanTab = gen_atan();
    localparam word_t KInit = word_t'(longint'(0.6072529350088813 * (2.0 ** WIDTH)));
    localparam word_t One   = word_t'(longint'(1) << WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StConv, StDone} state_e;

    state_e               state_q, state_d;
    word_t                x_q, x_d, y_q, y_d, z_q, z_d;
    word_t                x_sh, y_sh;
    logic [CW-1:0]        i_q, i_d;
    logic [WIDTH+1:0]     result_q, result_d;

    assign x_sh = x_q >>> i_q;
    assign y_sh = y_q >>> i_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid_i) state_d = StRun;
            StRun:  if (i_q == CW'(ITER - 1)) state_d = StConv;
            StConv: state_d = StDone;
            StDone: if (out_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == StIdle);
        out_valid_o = (state_q == StDone);
        result_o    = result_q;
    end

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        i_d      = i_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    x_d = KInit;
                    y_d = '0;
                    z_d = word_t'($signed(theta_i));
                    i_d = '0;
                end
            end
            StRun: begin
                // d = +1 when z >= 0: rotate toward zero residual angle
                if (!z_q[DW-1]) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - $signed(AtanTab[i_q]);
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + $signed(AtanTab[i_q]);
                end
                i_d = i_q + CW'(1);
            end
            StConv: begin
                if (x_q[DW-1]) begin
                    result_d = '0;
                end else if (x_q > One) begin
                    result_d = {2'b01, {WIDTH{1'b0}}};
                end else begin
                    result_d = {1'b0, x_q[WIDTH:0]};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            i_q      <= '0;
            result_q <= '0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            i_q      <= i_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_cordic_cos_iter.sv
// Directed and randomized bench for cordic_cos_iter; results are compared against
// a real-valued cos() reference with a 16 LSB tolerance.
module tb_cordic_cos_iter;

    localparam int unsigned W  = 23;
    localparam int unsigned IT = 24;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W+1:0] theta;
    logic         out_valid;
    logic         out_ready;
    logic [W+1:0] result;

    int checks = 0;
    int errors = 0;

    cordic_cos_iter #(
        .WIDTH(W),
        .ITER (IT)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .theta_i    (theta),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint model_cos(input logic [W+1:0] th);
        real a;
        a = real'($signed(th)) / (2.0 ** W);
        return longint'($cos(a) * (2.0 ** W));
    endfunction

    task automatic check_cos(input string tag, input logic [W+1:0] res, input logic [W+1:0] th);
        longint exp_v;
        longint diff;
        logic   ok;
        exp_v = model_cos(th);
        diff  = longint'(res) - exp_v;
        ok    = (diff <= 16) && (diff >= -16) && (res[W+1] == 1'b0)
                && (!res[W] || res == (W+2)'(longint'(1) << W));
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h +/-16 (theta %0h)", tag, res, exp_v, th);
        end
    endtask

    // Caller sits at a negedge; returns at the negedge right after the accepting edge.
    task automatic submit(input logic [W+1:0] th);
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("submit_ready", in_ready, 1);
        in_valid = 1'b1;
        theta    = th;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [W+1:0] res, output int lat);
        int n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        res = result;
    endtask

    task automatic run_job(input string tag, input logic [W+1:0] th);
        logic [W+1:0] res;
        int           lat;
        submit(th);
        wait_result(res, lat);
        check({tag, "_lat"}, lat, IT + 1);
        check_cos(tag, res, th);
        @(negedge clk);
        check({tag, "_vdrop"}, out_valid, 0);
    endtask

    initial begin
        logic [W+1:0] res;
        logic [W+1:0] res0;
        int           lat;
        int           seen;
        int           v;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        theta     = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // theta = 0: latency, one-cycle pulse, integer bit only for exactly 1.0
        submit('0);
        wait_result(res, lat);
        check("t0_lat", lat, IT + 1);
        check_cos("t0_cos", res, '0);
        check("t0_bit24", res[W+1], 0);
        @(negedge clk);
        check("t0_pulse", out_valid, 0);
        check("t0_ready", in_ready, 1);

        run_job("pos_one", 25'h0800000);
        run_job("neg_one", 25'h1800000);
        run_job("half", 25'h0400000);

        // Backpressure, then drain with in_valid held high across the drain edge
        out_ready = 1'b0;
        submit(25'h0400000);
        wait_result(res0, lat);
        check("bp_lat", lat, IT + 1);
        check_cos("bp_cos", res0, 25'h0400000);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_result", result, res0);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        theta     = 25'h0800000;
        @(negedge clk);
        check("drain_valid", out_valid, 0);
        check("drain_no_accept", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("drain_next_accept", in_ready, 0);
        wait_result(res, lat);
        check("drain_job_lat", lat, IT + 1);
        check_cos("drain_job_cos", res, 25'h0800000);
        @(negedge clk);

        // Busy input: second angle pulsed during RUN must be dropped
        submit('0);
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        theta    = 25'h0400000;
        @(negedge clk);
        in_valid = 1'b0;
        theta    = '0;
        wait_result(res, lat);
        check("busy_lat", lat, IT + 1 - 4);
        check_cos("busy_cos", res, '0);
        seen = 0;
        repeat (IT + 8) begin
            @(negedge clk);
            if (out_valid === 1'b1 || in_ready !== 1'b1) seen++;
        end
        check("busy_no_second", seen, 0);

        // Reset mid-run at roughly iteration 10
        submit(25'h0400000);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        run_job("post_rst", 25'h0400000);

        // Random legal angles in [-1.0, +1.0]
        for (int k = 0; k < 16; k++) begin
            v = int'($urandom_range(0, 2 * (1 << W))) - (1 << W);
            run_job("rand", v[W+1:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
